// File: rtl/ram_if_pkg.sv
// Shared types and constants for the PIO RAM nibble-stream serializers.
package ram_if_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DATA,
        WAIT_DATA
    } state_t;

    localparam logic [3:0]  CMD_WRITE        = 4'h1;
    localparam logic [3:0]  CMD_READ         = 4'h2;

    localparam int unsigned WORD_BITS        = 16;
    localparam int unsigned NIBBLE_BITS      = 4;
    localparam int unsigned NIBBLES_PER_WORD = WORD_BITS / NIBBLE_BITS;
    localparam int unsigned CNT_BITS         = $clog2(NIBBLES_PER_WORD);

endpackage

// File: rtl/ram_write_serializer_nibble_shifter.sv
// 16-bit load/shift register with a nibble counter; the low nibble is always
// the next one to present, and last_nibble marks the final nibble of a word.
module nibble_shifter
    import ram_if_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [WORD_BITS-1:0]   load_word,
    input  logic                   shift,
    input  logic                   cnt_clr,
    output logic [NIBBLE_BITS-1:0] nibble,
    output logic                   last_nibble
);

    logic [WORD_BITS-1:0] sreg;
    logic [CNT_BITS-1:0]  cnt;

    // Load takes priority; a shift moves the next nibble down and counts it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (load) begin
            sreg <= load_word;
            cnt  <= '0;
        end else if (shift) begin
            sreg <= sreg >> NIBBLE_BITS;
            cnt  <= cnt_clr ? '0 : cnt + 1'b1;
        end
    end

    assign nibble      = sreg[NIBBLE_BITS-1:0];
    assign last_nibble = (cnt == CNT_BITS'(NIBBLES_PER_WORD - 1));

endmodule

// File: rtl/ram_write_serializer.sv
// Turns alternating address/data write words into a command + 4 address
// nibbles + 4 data nibbles stream with ready/valid flow control on the pins.
module ram_write_serializer
    import ram_if_pkg::*;
#(
    parameter logic [3:0]  CMD_WRITE = 4'h1,
    parameter int unsigned TX_BITS   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        write_en,
    input  logic        write_mode_data,
    input  logic [15:0] w_addr,
    input  logic [15:0] w_data,
    output logic        write_accepted,
    output logic [3:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        proto_err
);

    if (TX_BITS != 4 || (16 % TX_BITS) != 0) begin : g_bad_tx_bits
        $error("ram_write_serializer: TX_BITS must be 4");
    end

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  tx_data_d;
    logic        tx_valid_d;
    logic        proto_err_d;
    logic        xfer;

    logic        sh_load;
    logic [15:0] sh_word;
    logic        sh_shift;
    logic        sh_cnt_clr;
    logic [3:0]  sh_nibble;
    logic        sh_last;

    assign xfer = tx_valid && tx_ready;

    nibble_shifter u_shifter (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (sh_load),
        .load_word   (sh_word),
        .shift       (sh_shift),
        .cnt_clr     (sh_cnt_clr),
        .nibble      (sh_nibble),
        .last_nibble (sh_last)
    );

    // Next-state, output-register next values, handshake and shifter control.
    always_comb begin
        state_d        = state_q;
        tx_data_d      = tx_data;
        tx_valid_d     = tx_valid;
        proto_err_d    = proto_err;
        write_accepted = 1'b0;
        sh_load        = 1'b0;
        sh_word        = w_addr;
        sh_shift       = 1'b0;
        sh_cnt_clr     = 1'b0;

        unique case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (write_en && !write_mode_data) begin
                    write_accepted = 1'b1;
                    sh_load        = 1'b1;
                    sh_word        = w_addr;
                    tx_data_d      = CMD_WRITE;
                    tx_valid_d     = 1'b1;
                    state_d        = CMD;
                end else if (write_en && write_mode_data) begin
                    proto_err_d = 1'b1;
                end
            end
            CMD: begin
                if (xfer) begin
                    tx_data_d  = sh_nibble;
                    sh_shift   = 1'b1;
                    sh_cnt_clr = 1'b1;
                    state_d    = ADDR;
                end
            end
            ADDR, DATA: begin
                if (xfer) begin
                    if (sh_last) begin
                        tx_valid_d = 1'b0;
                        state_d    = (state_q == ADDR) ? WAIT_DATA : IDLE;
                    end else begin
                        tx_data_d = sh_nibble;
                        sh_shift  = 1'b1;
                    end
                end
            end
            WAIT_DATA: begin
                tx_valid_d = 1'b0;
                // The first data nibble goes straight to tx_data, so the
                // shifter is loaded with the remaining three nibbles.
                if (write_en && write_mode_data) begin
                    write_accepted = 1'b1;
                    sh_load        = 1'b1;
                    sh_word        = w_data >> TX_BITS;
                    tx_data_d      = w_data[TX_BITS-1:0];
                    tx_valid_d     = 1'b1;
                    state_d        = DATA;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

    // State and pin-side output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_data   <= '0;
            tx_valid  <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_data   <= tx_data_d;
            tx_valid  <= tx_valid_d;
            proto_err <= proto_err_d;
        end
    end

endmodule

// File: tb/tb_ram_write_serializer.sv
// Directed bench for ram_write_serializer: single write, backpressure,
// protocol error, early address, async reset and back-to-back pairs.
module tb_ram_write_serializer;
    import ram_if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write_en;
    logic        write_mode_data;
    logic [15:0] w_addr;
    logic [15:0] w_data;
    logic        write_accepted;
    logic [3:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        proto_err;

    int errors = 0;
    int checks = 0;

    ram_write_serializer #(.CMD_WRITE(4'h1), .TX_BITS(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .write_en        (write_en),
        .write_mode_data (write_mode_data),
        .w_addr          (w_addr),
        .w_data          (w_data),
        .write_accepted  (write_accepted),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .proto_err       (proto_err)
    );

    always #5 clk = ~clk;

    // Generator-model run state and captured trace
    logic [15:0] pair_addr[3];
    logic [15:0] pair_data[3];
    bit          stall[64];
    logic [3:0]  cap_nib[32];
    int          cap_cyc[32];
    int          cap_n;
    int          acc_cyc[8];
    int          acc_n;
    int          end_cyc;
    bit          run_done;
    bit          end_idle;
    bit          tr_v[64];
    logic [3:0]  tr_d[64];

    int          base_cyc[9] = '{1, 2, 3, 4, 5, 7, 8, 9, 10};

    function automatic logic [3:0] exp_nib(input logic [15:0] a, input logic [15:0] d, input int k);
        logic [15:0] w;
        if (k == 0) return 4'h1;
        w = (k <= 4) ? a : d;
        return 4'((w >> (4 * ((k - 1) % 4))) & 16'h000F);
    endfunction

    task automatic clear_stall();
        foreach (stall[i]) stall[i] = 1'b0;
    endtask

    // Drives n address/data pairs like the generator (phase toggles on
    // write_accepted); call at posedge+1 with the DUT idle.
    task automatic run_pairs(input int n, input int budget);
        int idx;
        bit phase;
        idx = 0;
        phase = 1'b0;
        cap_n = 0;
        acc_n = 0;
        end_cyc = -1;
        run_done = 1'b0;
        end_idle = 1'b0;
        for (int cyc = 0; cyc < budget && !run_done; cyc++) begin
            tx_ready = !stall[cyc];
            if (idx < n) begin
                write_en = 1'b1;
                write_mode_data = phase;
                w_addr = pair_addr[idx];
                w_data = pair_data[idx];
            end else begin
                write_en = 1'b0;
                write_mode_data = 1'b0;
            end
            @(negedge clk);
            tr_v[cyc] = tx_valid;
            tr_d[cyc] = tx_data;
            if (tx_valid && tx_ready && cap_n < 32) begin
                cap_nib[cap_n] = tx_data;
                cap_cyc[cap_n] = cyc;
                cap_n++;
            end
            if (write_accepted) begin
                if (acc_n < 8) begin
                    acc_cyc[acc_n] = cyc;
                    acc_n++;
                end
                if (phase) idx++;
                phase = !phase;
            end
            if (idx == n && cap_n == 9 * n && !tx_valid) begin
                run_done = 1'b1;
                end_cyc = cyc;
                end_idle = (dut.state_q == IDLE);
            end
            @(posedge clk);
            #1;
        end
        write_en = 1'b0;
        write_mode_data = 1'b0;
        tx_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        write_en = 1'b1;
        write_mode_data = 1'b1;
        w_addr = '0;
        w_data = '0;
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL reset_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 4'h0) begin errors++; $display("FAIL reset_tx_data got=%h exp=0", tx_data); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_proto_err got=%0b exp=0", proto_err); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL reset_state got=%0d exp=IDLE", dut.state_q); end
        write_en = 1'b0;
        write_mode_data = 1'b0;
        #1;
        checks++; if (write_accepted !== 1'b0) begin errors++; $display("FAIL reset_accepted got=%0b exp=0", write_accepted); end
        tx_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_write();
        logic [3:0] exp_seq[9] = '{4'h1, 4'h4, 4'h3, 4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA};
        clear_stall();
        pair_addr[0] = 16'h1234;
        pair_data[0] = 16'hABCD;
        run_pairs(1, 40);
        checks++; if (run_done !== 1'b1) begin errors++; $display("FAIL single_done got=%0b exp=1", run_done); end
        checks++; if (cap_n !== 9) begin errors++; $display("FAIL single_count got=%0d exp=9", cap_n); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (cap_nib[k] !== exp_seq[k]) begin errors++; $display("FAIL single_nib[%0d] got=%h exp=%h", k, cap_nib[k], exp_seq[k]); end
            checks++; if (cap_cyc[k] !== base_cyc[k]) begin errors++; $display("FAIL single_cyc[%0d] got=%0d exp=%0d", k, cap_cyc[k], base_cyc[k]); end
        end
        checks++; if (acc_cyc[0] !== 0) begin errors++; $display("FAIL single_addr_acc got=%0d exp=0", acc_cyc[0]); end
        checks++; if (acc_cyc[1] !== 6) begin errors++; $display("FAIL single_data_acc got=%0d exp=6", acc_cyc[1]); end
        checks++; if (end_cyc !== 11) begin errors++; $display("FAIL single_end got=%0d exp=11", end_cyc); end
        checks++; if (end_idle !== 1'b1) begin errors++; $display("FAIL single_idle got=%0b exp=1", end_idle); end
    endtask

    task automatic test_backpressure();
        logic [3:0] exp_seq[9] = '{4'h1, 4'h4, 4'h3, 4'h2, 4'h1, 4'hD, 4'hC, 4'hB, 4'hA};
        int exp_cyc[9] = '{1, 4, 5, 6, 7, 9, 10, 12, 13};
        clear_stall();
        stall[2] = 1'b1;
        stall[3] = 1'b1;
        stall[8] = 1'b1;
        stall[11] = 1'b1;
        pair_addr[0] = 16'h1234;
        pair_data[0] = 16'hABCD;
        run_pairs(1, 40);
        checks++; if (cap_n !== 9) begin errors++; $display("FAIL bp_count got=%0d exp=9", cap_n); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (cap_nib[k] !== exp_seq[k]) begin errors++; $display("FAIL bp_nib[%0d] got=%h exp=%h", k, cap_nib[k], exp_seq[k]); end
            checks++; if (cap_cyc[k] !== exp_cyc[k]) begin errors++; $display("FAIL bp_cyc[%0d] got=%0d exp=%0d", k, cap_cyc[k], exp_cyc[k]); end
        end
        checks++; if (tr_v[2] !== 1'b1 || tr_d[2] !== 4'h4) begin errors++; $display("FAIL bp_hold2 got=%0b/%h exp=1/4", tr_v[2], tr_d[2]); end
        checks++; if (tr_v[3] !== 1'b1 || tr_d[3] !== 4'h4) begin errors++; $display("FAIL bp_hold3 got=%0b/%h exp=1/4", tr_v[3], tr_d[3]); end
        checks++; if (tr_v[11] !== 1'b1 || tr_d[11] !== 4'hB) begin errors++; $display("FAIL bp_hold11 got=%0b/%h exp=1/b", tr_v[11], tr_d[11]); end
        checks++; if (acc_cyc[1] !== 8) begin errors++; $display("FAIL bp_data_acc got=%0d exp=8", acc_cyc[1]); end
        checks++; if (end_cyc !== 14) begin errors++; $display("FAIL bp_end got=%0d exp=14", end_cyc); end
    endtask

    task automatic test_early_address();
        logic [3:0] exp_d[4] = '{4'h7, 4'h5, 4'h3, 4'h1};
        tx_ready = 1'b1;
        for (int cyc = 0; cyc < 14; cyc++) begin
            write_en = (cyc <= 8);
            write_mode_data = (cyc >= 8);
            w_addr = 16'h00FF;
            w_data = 16'h1357;
            @(negedge clk);
            if (cyc == 0) begin
                checks++; if (write_accepted !== 1'b1) begin errors++; $display("FAIL early_addr_acc got=%0b exp=1", write_accepted); end
            end
            if (cyc == 6 || cyc == 7) begin
                checks++; if (write_accepted !== 1'b0) begin errors++; $display("FAIL early_acc[%0d] got=%0b exp=0", cyc, write_accepted); end
                checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL early_err[%0d] got=%0b exp=0", cyc, proto_err); end
                checks++; if (dut.state_q !== WAIT_DATA) begin errors++; $display("FAIL early_state[%0d] got=%0d exp=WAIT_DATA", cyc, dut.state_q); end
            end
            if (cyc == 8) begin
                checks++; if (write_accepted !== 1'b1) begin errors++; $display("FAIL early_data_acc got=%0b exp=1", write_accepted); end
            end
            if (cyc >= 9 && cyc <= 12) begin
                checks++; if (tx_valid !== 1'b1 || tx_data !== exp_d[cyc-9]) begin errors++; $display("FAIL early_data[%0d] got=%0b/%h exp=1/%h", cyc, tx_valid, tx_data, exp_d[cyc-9]); end
            end
            if (cyc == 13) begin
                checks++; if (dut.state_q !== IDLE || proto_err !== 1'b0) begin errors++; $display("FAIL early_end got=%0d/%0b exp=IDLE/0", dut.state_q, proto_err); end
            end
            @(posedge clk);
            #1;
        end
        write_en = 1'b0;
        write_mode_data = 1'b0;
    endtask

    task automatic test_proto_err();
        logic [3:0] exp_seq[9] = '{4'h1, 4'hE, 4'hF, 4'hA, 4'hC, 4'h4, 4'h3, 4'h2, 4'h1};
        tx_ready = 1'b1;
        write_en = 1'b1;
        write_mode_data = 1'b1;
        w_data = 16'h5555;
        @(negedge clk);
        checks++; if (write_accepted !== 1'b0) begin errors++; $display("FAIL perr_acc got=%0b exp=0", write_accepted); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_before got=%0b exp=0", proto_err); end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        write_mode_data = 1'b0;
        for (int c = 1; c < 4; c++) begin
            @(negedge clk);
            checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky[%0d] got=%0b exp=1", c, proto_err); end
            checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL perr_state[%0d] got=%0d exp=IDLE", c, dut.state_q); end
            @(posedge clk);
            #1;
        end
        clear_stall();
        pair_addr[0] = 16'hCAFE;
        pair_data[0] = 16'h1234;
        run_pairs(1, 40);
        checks++; if (cap_n !== 9) begin errors++; $display("FAIL perr_count got=%0d exp=9", cap_n); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (cap_nib[k] !== exp_seq[k]) begin errors++; $display("FAIL perr_nib[%0d] got=%h exp=%h", k, cap_nib[k], exp_seq[k]); end
        end
        checks++; if (end_cyc !== 11) begin errors++; $display("FAIL perr_end got=%0d exp=11", end_cyc); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_after got=%0b exp=1", proto_err); end
    endtask

    task automatic test_async_reset();
        logic [3:0] exp_seq[9] = '{4'h1, 4'h1, 4'h0, 4'h0, 4'h0, 4'hD, 4'h0, 4'h0, 4'hF};
        tx_ready = 1'b1;
        write_en = 1'b1;
        write_mode_data = 1'b0;
        w_addr = 16'h1234;
        @(negedge clk);
        checks++; if (write_accepted !== 1'b1) begin errors++; $display("FAIL ar_acc got=%0b exp=1", write_accepted); end
        @(posedge clk);
        #1;
        write_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (tx_valid !== 1'b1 || tx_data !== 4'h2) begin errors++; $display("FAIL ar_mid got=%0b/%h exp=1/2", tx_valid, tx_data); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (tx_valid !== 1'b0) begin errors++; $display("FAIL ar_tx_valid got=%0b exp=0", tx_valid); end
        checks++; if (tx_data !== 4'h0) begin errors++; $display("FAIL ar_tx_data got=%h exp=0", tx_data); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL ar_proto_err got=%0b exp=0", proto_err); end
        checks++; if (dut.state_q !== IDLE) begin errors++; $display("FAIL ar_state got=%0d exp=IDLE", dut.state_q); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_stall();
        pair_addr[0] = 16'h0001;
        pair_data[0] = 16'hF00D;
        run_pairs(1, 40);
        checks++; if (cap_n !== 9) begin errors++; $display("FAIL ar_count got=%0d exp=9", cap_n); end
        for (int k = 0; k < 9; k++) begin
            checks++; if (cap_nib[k] !== exp_seq[k]) begin errors++; $display("FAIL ar_nib[%0d] got=%h exp=%h", k, cap_nib[k], exp_seq[k]); end
        end
        checks++; if (end_cyc !== 11) begin errors++; $display("FAIL ar_end got=%0d exp=11", end_cyc); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] e;
        clear_stall();
        pair_addr[0] = 16'h1234; pair_data[0] = 16'hABCD;
        pair_addr[1] = 16'hBEEF; pair_data[1] = 16'h0F0F;
        pair_addr[2] = 16'h0000; pair_data[2] = 16'hFFFF;
        run_pairs(3, 60);
        checks++; if (run_done !== 1'b1) begin errors++; $display("FAIL b2b_done got=%0b exp=1", run_done); end
        checks++; if (cap_n !== 27) begin errors++; $display("FAIL b2b_count got=%0d exp=27", cap_n); end
        for (int p = 0; p < 3; p++) begin
            for (int k = 0; k < 9; k++) begin
                e = exp_nib(pair_addr[p], pair_data[p], k);
                checks++; if (cap_nib[9*p+k] !== e) begin errors++; $display("FAIL b2b_nib[%0d] got=%h exp=%h", 9*p+k, cap_nib[9*p+k], e); end
                checks++; if (cap_cyc[9*p+k] !== 11*p + base_cyc[k]) begin errors++; $display("FAIL b2b_cyc[%0d] got=%0d exp=%0d", 9*p+k, cap_cyc[9*p+k], 11*p + base_cyc[k]); end
            end
            checks++; if (acc_cyc[2*p] !== 11*p) begin errors++; $display("FAIL b2b_addr_acc[%0d] got=%0d exp=%0d", p, acc_cyc[2*p], 11*p); end
            checks++; if (acc_cyc[2*p+1] !== 11*p + 6) begin errors++; $display("FAIL b2b_data_acc[%0d] got=%0d exp=%0d", p, acc_cyc[2*p+1], 11*p + 6); end
        end
        checks++; if (end_cyc !== 33) begin errors++; $display("FAIL b2b_end got=%0d exp=33", end_cyc); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_backpressure();
        test_early_address();
        test_proto_err();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
